// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets,
// control/status bit positions and prescaler divider encodings.
package timer_pkg;

  // Per-channel register offsets within a channel's 4-word window
  typedef enum logic [1:0] {
    OFF_TDR  = 2'd0,
    OFF_TCR  = 2'd1,
    OFF_TSR  = 2'd2,
    OFF_TCNT = 2'd3
  } off_e;

  // TCR bit positions
  localparam int TCR_LOAD   = 7;
  localparam int TCR_ARLD   = 6;
  localparam int TCR_DN     = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_IE_OVF = 3;
  localparam int TCR_IE_UDF = 2;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // TSR bit positions
  localparam int TSR_UDF = 1;
  localparam int TSR_OVF = 0;

  // Prescaler divider select
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // Prescaler bits that must all be ones for a tick at the selected divider
  function automatic logic [3:0] cks_mask(input cks_e cks);
    logic [3:0] m;
    m = 4'b0001;
    case (cks)
      CKS_DIV2:  m = 4'b0001;
      CKS_DIV4:  m = 4'b0011;
      CKS_DIV8:  m = 4'b0111;
      CKS_DIV16: m = 4'b1111;
      default:   m = 4'b0001;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_mc_if.sv
// APB slave bus bundle for timer_mc.
interface timer_mc_if #(
  parameter int CNT_W = 16,
  parameter int AW    = 4
);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [AW-1:0]    paddr;
  logic [CNT_W-1:0] pwdata;
  logic [CNT_W-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: reload register, control, sticky flags, prescaler
// and the up/down counter with optional auto-reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  off_e             i_off,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_tdr,
  output logic [7:0]       o_tcr,
  output logic [1:0]       o_tsr,
  output logic [CNT_W-1:0] o_tcnt,
  output logic             o_irq
);

  logic [CNT_W-1:0] r_tdr;
  logic [6:0]       r_tcr;   // load bit is a strobe and is never stored
  logic [1:0]       r_tsr;
  logic [CNT_W-1:0] r_tcnt;
  logic [3:0]       r_psc;

  logic       w_wr_tdr, w_wr_tcr, w_wr_tsr;
  logic       w_load, w_en, w_dn, w_arld, w_tick;
  logic       w_ovf_set, w_udf_set;
  logic [1:0] w_tsr_clr;
  logic [3:0] w_mask;

  assign w_wr_tdr = i_wr && (i_off == OFF_TDR);
  assign w_wr_tcr = i_wr && (i_off == OFF_TCR);
  assign w_wr_tsr = i_wr && (i_off == OFF_TSR);
  assign w_load   = w_wr_tcr && i_wdata[TCR_LOAD];

  assign w_en   = r_tcr[TCR_EN];
  assign w_dn   = r_tcr[TCR_DN];
  assign w_arld = r_tcr[TCR_ARLD];
  assign w_mask = cks_mask(cks_e'(r_tcr[TCR_CKS_HI:TCR_CKS_LO]));
  assign w_tick = w_en && ((r_psc & w_mask) == w_mask);

  // A load on the same edge as a tick wins, so it suppresses the flag too
  assign w_ovf_set = w_tick && !w_load && !w_dn && (r_tcnt == {CNT_W{1'b1}});
  assign w_udf_set = w_tick && !w_load &&  w_dn && (r_tcnt == '0);
  assign w_tsr_clr = w_wr_tsr ? i_wdata[1:0] : 2'b00;

  // Reload and control registers
  // NOTE: every register here has an async reset; sequential blocks use
  // non-blocking assignments only so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdr <= '0;
      r_tcr <= '0;
    end else begin
      if (w_wr_tdr) r_tdr <= i_wdata;
      if (w_wr_tcr) r_tcr <= i_wdata[6:0];
    end
  end

  // Prescaler: free-runs while enabled, cleared by load or disable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (w_load || !w_en || (w_wr_tcr && !i_wdata[TCR_EN])) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 4'd1;
    end
  end

  // Counter: load has priority over a tick; wrap reloads TDR or the end value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_load) begin
      r_tcnt <= r_tdr;
    end else if (w_tick) begin
      if (w_dn) begin
        if (r_tcnt == '0) r_tcnt <= w_arld ? r_tdr : {CNT_W{1'b1}};
        else              r_tcnt <= r_tcnt - CNT_W'(1);
      end else begin
        if (r_tcnt == {CNT_W{1'b1}}) r_tcnt <= w_arld ? r_tdr : '0;
        else                         r_tcnt <= r_tcnt + CNT_W'(1);
      end
    end
  end

  // Sticky flags: write-1-to-clear, a same-edge set overrides the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tsr <= '0;
    end else begin
      r_tsr[TSR_OVF] <= (r_tsr[TSR_OVF] & ~w_tsr_clr[TSR_OVF]) | w_ovf_set;
      r_tsr[TSR_UDF] <= (r_tsr[TSR_UDF] & ~w_tsr_clr[TSR_UDF]) | w_udf_set;
    end
  end

  assign o_tdr  = r_tdr;
  assign o_tcr  = {1'b0, r_tcr};
  assign o_tsr  = r_tsr;
  assign o_tcnt = r_tcnt;
  assign o_irq  = (r_tsr[TSR_OVF] & r_tcr[TCR_IE_OVF]) |
                  (r_tsr[TSR_UDF] & r_tcr[TCR_IE_UDF]);

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer behind a zero-wait-state APB slave: address decode,
// per-channel write strobes, read mux and out-of-range error.
module timer_mc
  import timer_pkg::*;
#(
  parameter int CH_NUM = 3,
  parameter int CNT_W  = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  timer_mc_if.slave         apb,
  output logic [CH_NUM-1:0] irq
);

  localparam int AW = $clog2(CH_NUM) + 2;

  logic [AW-1:0]    w_ch;
  off_e             w_off;
  logic             w_ch_ok;
  logic             w_access;
  logic             w_wr;
  logic [CNT_W-1:0] w_rdata;

  logic [CNT_W-1:0] w_tdr  [CH_NUM];
  logic [7:0]       w_tcr  [CH_NUM];
  logic [1:0]       w_tsr  [CH_NUM];
  logic [CNT_W-1:0] w_tcnt [CH_NUM];

  assign w_ch     = apb.paddr >> 2;
  assign w_off    = off_e'(apb.paddr[1:0]);
  assign w_ch_ok  = (w_ch < AW'(CH_NUM));
  assign w_access = apb.psel && apb.penable;
  assign w_wr     = w_access && apb.pwrite;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (pclk),
      .rst_n   (presetn),
      .i_wr    (w_wr && w_ch_ok && (w_ch == AW'(g))),
      .i_off   (w_off),
      .i_wdata (apb.pwdata),
      .o_tdr   (w_tdr[g]),
      .o_tcr   (w_tcr[g]),
      .o_tsr   (w_tsr[g]),
      .o_tcnt  (w_tcnt[g]),
      .o_irq   (irq[g])
    );
  end

  // Combinational read mux; zero outside a valid read
  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    w_rdata = '0;
    if (apb.psel && !apb.pwrite && w_ch_ok) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_ch == AW'(i)) begin
          case (w_off)
            OFF_TDR:  w_rdata = w_tdr[i];
            OFF_TCR:  w_rdata = CNT_W'(w_tcr[i]);
            OFF_TSR:  w_rdata = CNT_W'(w_tsr[i]);
            OFF_TCNT: w_rdata = w_tcnt[i];
            default:  w_rdata = '0;
          endcase
        end
      end
    end
  end

  assign apb.prdata  = w_rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = w_access && !w_ch_ok;

endmodule

// File: tb/tb_timer_mc.sv
// Self-checking bench for timer_mc: integer-level register model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_timer_mc;

  localparam int CH_NUM = 3;
  localparam int CNT_W  = 16;
  localparam int AW     = 4;
  localparam int MAXV   = 65535;

  logic              pclk    = 1'b0;
  logic              presetn = 1'b0;
  logic [CH_NUM-1:0] irq;
  logic              last_slverr;

  int n_vec = 0;
  int n_err = 0;

  timer_mc_if #(.CNT_W(CNT_W), .AW(AW)) bus ();

  timer_mc #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus.slave),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_tdr   [CH_NUM];
  int m_tcr   [CH_NUM];
  int m_tsr   [CH_NUM];
  int m_cnt   [CH_NUM];
  int m_phase [CH_NUM];   // enabled cycles elapsed, modulo 16

  function automatic int mread(input int addr);
    int ch, off;
    ch  = addr / 4;
    off = addr % 4;
    if (ch >= CH_NUM) return 0;
    case (off)
      0:       return m_tdr[ch];
      1:       return m_tcr[ch];
      2:       return m_tsr[ch];
      default: return m_cnt[ch];
    endcase
  endfunction

  function automatic logic mirq(input int c);
    return (((m_tsr[c] & 1) != 0) && ((m_tcr[c] & 8) != 0)) ||
           (((m_tsr[c] & 2) != 0) && ((m_tcr[c] & 4) != 0));
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH_NUM; c++) begin
      m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; m_cnt[c] = 0; m_phase[c] = 0;
    end
  endtask

  task automatic model_step();
    int  ch, off, wd, div, setf;
    bit  wr, en, tick, hit, load, dn, arld;
    wr  = bus.psel && bus.penable && bus.pwrite;
    ch  = int'(bus.paddr) / 4;
    off = int'(bus.paddr) % 4;
    wd  = int'(bus.pwdata);
    for (int c = 0; c < CH_NUM; c++) begin
      div  = 2 << (m_tcr[c] & 3);
      en   = (m_tcr[c] & 16) != 0;
      dn   = (m_tcr[c] & 32) != 0;
      arld = (m_tcr[c] & 64) != 0;
      tick = en && ((m_phase[c] % div) == div - 1);
      hit  = wr && (ch == c);
      load = hit && (off == 1) && ((wd & 128) != 0);
      setf = 0;
      if (load) m_cnt[c] = m_tdr[c];
      else if (tick) begin
        if (dn) begin
          if (m_cnt[c] == 0) begin m_cnt[c] = arld ? m_tdr[c] : MAXV; setf = 2; end
          else m_cnt[c] = m_cnt[c] - 1;
        end else begin
          if (m_cnt[c] == MAXV) begin m_cnt[c] = arld ? m_tdr[c] : 0; setf = 1; end
          else m_cnt[c] = m_cnt[c] + 1;
        end
      end
      if (load || !en || (hit && off == 1 && (wd & 16) == 0)) m_phase[c] = 0;
      else m_phase[c] = (m_phase[c] + 1) % 16;
      if (hit && off == 0) m_tdr[c] = wd;
      if (hit && off == 1) m_tcr[c] = wd & 'h7F;
      if (hit && off == 2) m_tsr[c] = m_tsr[c] & ~(wd & 3);
      m_tsr[c] = m_tsr[c] | setf;
    end
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) model_clear();
    else          model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge pclk) begin
    logic [CH_NUM-1:0] exp_irq;
    int                exp_rd;
    #1;
    for (int c = 0; c < CH_NUM; c++) exp_irq[c] = mirq(c);
    exp_rd = (bus.psel && !bus.pwrite) ? mread(int'(bus.paddr)) : 0;
    check("cyc_prdata", 32'(bus.prdata), exp_rd);
    check("cyc_pslverr", 32'(bus.pslverr),
          32'(bus.psel && bus.penable && ((int'(bus.paddr) >> 2) >= CH_NUM)));
    check("cyc_pready", 32'(bus.pready), 1);
    check("cyc_irq", 32'(irq), 32'(exp_irq));
  end

  // ---------------- bus tasks ----------------
  task automatic apb_write(input int addr, input int data);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = AW'(addr);
    bus.pwdata  = CNT_W'(data);
    @(negedge pclk);
    bus.penable = 1'b1;
    #1 last_slverr = bus.pslverr;
    @(negedge pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic peek(input string name, input int addr, input int exp);
    logic [31:0] got;
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = AW'(addr);
    #1 got = 32'(bus.prdata);
    check(name, got, exp);
    check({name, "_model"}, got, mread(addr));
    bus.psel = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    model_clear();
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Reset state
    check("rst_irq", 32'(irq), 0);
    check("rst_pslverr", 32'(bus.pslverr), 0);
    for (int a = 0; a < 12; a++) peek($sformatf("rst_rd%0d", a), a, 0);

    // Ch0 count-down underflow: TDR=3, /4, wrap 16 pclk after enable
    apb_write(0, 'h0003);
    apb_write(1, 'h80);
    check("wr_slverr", 32'(last_slverr), 0);
    peek("ch0_tcnt_load", 3, 'h0003);
    apb_write(1, 'h31);
    repeat (15) @(negedge pclk);
    peek("ch0_udf_pre", 2, 0);
    @(negedge pclk);
    peek("ch0_udf", 2, 2);
    peek("ch0_tcnt_wrap", 3, 'hFFFF);
    check("ch0_irq_masked", 32'(irq[0]), 0);

    // Ch1 count-up auto-reload with interrupt: wrap 6 pclk after enable
    apb_write(4, 'hFFFD);
    apb_write(5, 'h80);
    apb_write(5, 'h58);
    repeat (5) @(negedge pclk);
    peek("ch1_ovf_pre", 6, 0);
    check("ch1_irq_pre", 32'(irq), 0);
    @(negedge pclk);
    peek("ch1_ovf", 6, 1);
    check("ch1_irq", 32'(irq), 'b010);
    peek("ch1_tcnt_reload", 7, 'hFFFD);

    // Ch0 W1C: reload-run at /2 with ie_udf; udf re-sets 8 pclk after load
    apb_write(1, 'hF4);
    check("ch0_irq_on", 32'(irq[0]), 1);
    apb_write(2, 'h02);
    peek("ch0_w1c", 2, 0);
    check("ch0_irq_cleared", 32'(irq[0]), 0);
    repeat (4) @(negedge pclk);
    apb_write(2, 'h02);               // lands on the re-set edge
    peek("ch0_w1c_collide", 2, 2);
    check("ch0_irq_collide", 32'(irq[0]), 1);

    // Out-of-range channel
    for (int a = 12; a < 16; a++) begin
      apb_write(a, 'h1234);
      check($sformatf("oob_slverr%0d", a), 32'(last_slverr), 1);
      peek($sformatf("oob_rd%0d", a), a, 0);
    end
    peek("oob_ch2_tdr", 8, 0);
    peek("oob_ch2_tcr", 9, 0);
    peek("oob_ch0_tdr", 0, 'h0003);
    peek("oob_ch1_tdr", 4, 'hFFFD);

    // Ch2 /16 count, then async reset mid-count
    apb_write(9, 'h13);
    repeat (40) @(negedge pclk);
    peek("ch2_tcnt_run", 11, 2);
    presetn = 1'b0;
    #1;
    check("arst_irq", 32'(irq), 0);
    peek("arst_ch2_tcnt", 11, 0);
    peek("arst_ch2_tcr", 9, 0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (40) @(negedge pclk);
    peek("post_rst_ch2_tcnt", 11, 0);
    peek("post_rst_ch0_tcnt", 3, 0);
    peek("post_rst_ch1_tsr", 6, 0);

    @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
